imem_loader: RTL
================

# imem_loader

Boot-time program loader that fills the CPU instruction memory from a byte stream, replacing the hierarchical memory pokes benches use today. It receives a framed, checksummed byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. It writes them to consecutive instruction-memory words starting at the program base address, and holds the CPU in reset until a frame has loaded cleanly. It sits between the external load port and `imem`'s write port, and drives the CPU's reset.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory word-address width
- `INSTR_W`, 32: instruction width (fixed at 4 bytes)
- `BASE_ADDR`, 10'h200: first word address written
- `SYNC_BYTE`, 8'hA5: frame start marker

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle re-arm pulse; returns loader to SYNC
- `in_valid`  in  1  byte-stream valid
- `in_data`  in  8  byte-stream data
- `in_ready`  out  1  loader can accept a byte this cycle
- `imem_we`  out  1  one-cycle write strobe to instruction memory
- `imem_addr`  out  ADDR_W  word address for write
- `imem_wdata`  out  INSTR_W  instruction word
- `cpu_hold`  out  1  drives CPU reset; high until a successful load
- `done`  out  1  frame loaded, checksum good (sticky until `start`/`reset`)
- `error`  out  1  frame rejected (sticky until `start`/`reset`)

## Operation
- Byte accepted iff `in_valid & in_ready`; `in_ready` = 1 in SYNC, LEN_HI, LEN_LO, DATA, CSUM; 0 in DONE, ERR.
- Frame: SYNC_BYTE, N[15:8], N[7:0], 4·N data bytes (MSB first per word), 1 checksum byte = XOR of all bytes from N[15:8] through last data byte.
- States and transitions:
  - SYNC: discard bytes ≠ SYNC_BYTE; on SYNC_BYTE → LEN_HI, clear checksum, byte and word counters.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO: on accept, if N > 2^ADDR_W − BASE_ADDR → ERR; if N = 0 → CSUM; else → DATA.
  - DATA: shift bytes into word register; on 4th byte issue write at BASE_ADDR + word_count, increment word_count. After word N → CSUM.
  - CSUM: on accept, match → DONE, mismatch → ERR.
  - DONE: `done`=1, `cpu_hold`=0. ERR: `error`=1, `cpu_hold`=1.
- `start` in any state → SYNC next cycle; clears `done`/`error`; reasserts `cpu_hold`; partial word discarded; already-written words not erased. A byte presented in the same cycle as `start` is not accepted (`in_ready` forced 0 that cycle).
- Address arithmetic is ADDR_W bits. The length check guarantees no wrap past the top of memory.

## Timing
- Reset values: `in_ready`=0 during reset then 1 (state SYNC), `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0.
- `imem_we` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted. `imem_addr`/`imem_wdata` are valid in that cycle and hold until the next write.
- Back-to-back bytes at full rate are sustained: no bubbles, so one word is written per 4 cycles.
- `done` rises and `cpu_hold` falls in the cycle after the checksum byte is accepted. The last `imem_we` precedes `cpu_hold` deassert by at least one cycle.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Memory contents are untouched.

## Structure
- Package `imem_loader_pkg`: state enum (SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR), default SYNC_BYTE, frame-length field width (16).
- Sub-module `byte_packer`: 8→32 shift register with 2-bit byte counter, `word_valid` pulse and clear input. The FSM, checksum and address counter stay in the top.

## Test plan
- Load 10-word sum-0-to-10 program (N=10, correct XOR) at full rate → 10 `imem_we` pulses at 0x200..0x209 with matching words. `done`=1, `cpu_hold` falls after the checksum, and the CPU then writes 55 to dmem[100].
- Same frame with checksum bit flipped → all 10 writes occur, `error`=1, `cpu_hold` stays 1. `start` then a good frame → `done`=1.
- Garbage bytes 0x00, 0xFF before SYNC_BYTE, plus random `in_valid` gaps → identical writes and `done` as the clean case.
- N=0, checksum 0x00 → no `imem_we`, `done`=1. N=513 → ERR right after LEN_LO, `in_ready`=0, no writes.
- Assert `reset` after 6 data bytes → outputs at reset values immediately. Only word 0x200 was written. Full reload succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         LEN_W         = 16;
endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; emits a registered one-cycle word_valid
// and holds the completed word until the next one is finished.
module byte_packer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic [7:0]   byte_in,
  output logic [1:0]   byte_cnt,
  output logic [W-1:0] word,
  output logic         word_valid
);
  logic [W-9:0] sr_q, sr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] word_q, word_d;
  logic         vld_q, vld_d;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[W-17:0], byte_in};
      cnt_d = cnt_q + 2'd1;
      // Separate output register so the word stays stable while the next one fills.
      if (cnt_q == 2'd3) begin
        word_d = {sr_q, byte_in};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word       = word_q;
  assign word_valid = vld_q;
endmodule

// File: rtl/imem_loader.sv
// Framed, checksummed byte-stream loader for instruction memory; holds the CPU
// in reset until a frame has been written and its checksum verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int               ADDR_W    = 10,
  parameter int               INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h200,
  parameter logic [7:0]       SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);
  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'((1 << ADDR_W) - int'(BASE_ADDR));

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, wcnt_q, wcnt_d, wcnt_inc, len_n;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d, error_q, error_d, hold_q, hold_d;
  logic              rdy_st, accept, pk_clr, pk_shift;
  logic [1:0]        byte_cnt;

  assign rdy_st   = (state_q != S_DONE) && (state_q != S_ERR);
  assign in_ready = rdy_st & ~start & ~reset;
  assign accept   = in_valid & in_ready;
  assign len_n    = {len_q[LEN_W-1:8], in_data};
  assign wcnt_inc = wcnt_q + LEN_W'(1);
  assign pk_shift = accept && (state_q == S_DATA);
  assign pk_clr   = start || (accept && (state_q == S_SYNC) && (in_data == SYNC_BYTE));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;
    if (start) begin
      state_d = S_SYNC;
      done_d  = 1'b0;
      error_d = 1'b0;
      hold_d  = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_SYNC: if (in_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          csum_d  = '0;
          wcnt_d  = '0;
        end
        S_LEN_HI: begin
          len_d[LEN_W-1:8] = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d  = len_n;
          csum_d = csum_q ^ in_data;
          if ({1'b0, len_n} > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_n == '0) state_d = S_CSUM;
          else                      state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ in_data;
          if (byte_cnt == 2'd3) begin
            addr_d = BASE_ADDR + wcnt_q[ADDR_W-1:0];
            wcnt_d = wcnt_inc;
            if (wcnt_inc == len_q) state_d = S_CSUM;
          end
        end
        S_CSUM: if (in_data == csum_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDR;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  byte_packer #(.W(INSTR_W)) u_packer (
    .clk       (clk),
    .rst       (reset),
    .clr       (pk_clr),
    .shift     (pk_shift),
    .byte_in   (in_data),
    .byte_cnt  (byte_cnt),
    .word      (imem_wdata),
    .word_valid(imem_we)
  );

  assign imem_addr = addr_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule
